// File: rtl/syscall_run_ctrl.sv
// Run/halt sequencer: decodes committed SYSCALL service codes and gates the core clock-enable.
// Latency: syscall commit -> cpu_en low next cycle; go press -> go_pulse 2 cycles after the rising sample.
// Backpressure: none; the core is stalled through cpu_en, and go is the only resume source.
//
// Ports:
//   clk, rst        - system clock, asynchronous active-low reset
//   go              - raw resume/step push button (asynchronous; synchronized here)
//   step_en         - single-step mode switch (level)
//   syscall, v0, a0 - decoder SYSCALL flag, service code and argument
//   cpu_en          - core commit enable
//   led_data        - last a0 shown by a display syscall
//   halted, paused  - state indicators
//   cycle_cnt       - saturating count of enabled cycles
//   disp_cnt        - wrapping count of display syscalls
module syscall_run_ctrl #(
    parameter logic [31:0] DISP_CODE = 32'd34,
    parameter logic [31:0] EXIT_CODE = 32'd10,
    parameter int          CNT_W     = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             go,
    input  logic             step_en,
    input  logic             syscall,
    input  logic [31:0]      v0,
    input  logic [31:0]      a0,
    output logic             cpu_en,
    output logic [31:0]      led_data,
    output logic             halted,
    output logic             paused,
    output logic [CNT_W-1:0] cycle_cnt,
    output logic [15:0]      disp_cnt
);

    localparam logic [1:0] ST_RUN   = 2'd0;
    localparam logic [1:0] ST_STEP  = 2'd1;
    localparam logic [1:0] ST_PAUSE = 2'd2;
    localparam logic [1:0] ST_HALT  = 2'd3;

    logic [1:0] state;
    logic [1:0] state_nxt;

    // go crosses into clk through s1/s2; s3 delays s2 so a held button
    // produces a single one-cycle pulse.
    logic go_s1;
    logic go_s2;
    logic go_s3;
    logic go_pulse;

    logic commit;
    logic disp_hit;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            go_s1 <= 1'b0;
            go_s2 <= 1'b0;
            go_s3 <= 1'b0;
        end else begin
            go_s1 <= go;
            go_s2 <= go_s1;
            go_s3 <= go_s2;
        end
    end

    assign go_pulse = go_s2 & ~go_s3;

    // In STEP the core advances only on the cycle carrying the go pulse.
    assign cpu_en = (state == ST_RUN) | ((state == ST_STEP) & go_pulse);
    assign paused = (state == ST_PAUSE);
    assign halted = (state == ST_HALT);

    // A syscall presented while the core is stalled is not executed.
    assign commit   = cpu_en & syscall;
    assign disp_hit = commit & (v0 != EXIT_CODE) & (v0 == DISP_CODE);

    always_comb begin
        state_nxt = state;
        if (commit) begin
            if (v0 == EXIT_CODE) begin
                state_nxt = ST_HALT;
            end else if (v0 != DISP_CODE) begin
                state_nxt = ST_PAUSE;
            end
            // Display service keeps the current RUN/STEP mode.
        end else begin
            case (state)
                ST_RUN:   if (step_en)  state_nxt = ST_STEP;
                ST_STEP:  if (!step_en) state_nxt = ST_RUN;
                // Leaving PAUSE consumes the go pulse; no instruction
                // executes on it because cpu_en is low in PAUSE.
                ST_PAUSE: if (go_pulse) state_nxt = step_en ? ST_STEP : ST_RUN;
                default:  state_nxt = state;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= ST_RUN;
        end else begin
            state <= state_nxt;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            led_data <= 32'd0;
            disp_cnt <= 16'd0;
        end else if (disp_hit) begin
            led_data <= a0;
            disp_cnt <= disp_cnt + 16'd1;
        end
    end

    // Saturates so a long run never reads back as a small count.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cycle_cnt <= '0;
        end else if (cpu_en && (cycle_cnt != {CNT_W{1'b1}})) begin
            cycle_cnt <= cycle_cnt + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_syscall_run_ctrl.sv
module tb_syscall_run_ctrl;

    logic        clk;
    logic        rst;
    logic        go;
    logic        step_en;
    logic        syscall;
    logic [31:0] v0;
    logic [31:0] a0;
    logic        cpu_en;
    logic [31:0] led_data;
    logic        halted;
    logic        paused;
    logic [31:0] cycle_cnt;
    logic [15:0] disp_cnt;

    int n_checks;
    int n_fail;

    syscall_run_ctrl #(
        .DISP_CODE(32'd34),
        .EXIT_CODE(32'd10),
        .CNT_W    (32)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .go       (go),
        .step_en  (step_en),
        .syscall  (syscall),
        .v0       (v0),
        .a0       (a0),
        .cpu_en   (cpu_en),
        .led_data (led_data),
        .halted   (halted),
        .paused   (paused),
        .cycle_cnt(cycle_cnt),
        .disp_cnt (disp_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // Advance one clock; inputs are driven and outputs sampled at negedge.
    task automatic tick();
        @(negedge clk);
    endtask

    task automatic do_syscall(input logic [31:0] code, input logic [31:0] arg);
        syscall = 1'b1;
        v0      = code;
        a0      = arg;
        tick();
        syscall = 1'b0;
        v0      = 32'd0;
        a0      = 32'd0;
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        rst      = 1'b0;
        go       = 1'b0;
        step_en  = 1'b0;
        syscall  = 1'b0;
        v0       = 32'd0;
        a0       = 32'd0;

        repeat (2) tick();
        rst = 1'b1;
        check("rst_cpu_en", {31'd0, cpu_en}, 32'd1);
        check("rst_halted", {31'd0, halted}, 32'd0);
        check("rst_paused", {31'd0, paused}, 32'd0);
        check("rst_cycle", cycle_cnt, 32'd0);
        check("rst_led", led_data, 32'd0);
        check("rst_disp", {16'd0, disp_cnt}, 32'd0);

        // Idle run
        for (int i = 0; i < 5; i++) begin
            check("idle_cpu_en", {31'd0, cpu_en}, 32'd1);
            tick();
        end
        check("idle_cycle", cycle_cnt, 32'd5);
        check("idle_led", led_data, 32'd0);
        check("idle_paused", {31'd0, paused}, 32'd0);
        check("idle_halted", {31'd0, halted}, 32'd0);

        // Display syscall
        do_syscall(32'd34, 32'hDEADBEEF);
        check("disp_led", led_data, 32'hDEADBEEF);
        check("disp_cnt", {16'd0, disp_cnt}, 32'd1);
        check("disp_cpu_en", {31'd0, cpu_en}, 32'd1);
        check("disp_cycle", cycle_cnt, 32'd6);

        // Unknown service pauses
        do_syscall(32'd5, 32'd0);
        check("pause_cpu_en", {31'd0, cpu_en}, 32'd0);
        check("pause_paused", {31'd0, paused}, 32'd1);
        check("pause_cycle", cycle_cnt, 32'd7);

        // Hold go for 20 cycles: resume exactly 3 edges after go rises
        go = 1'b1;
        tick();
        check("go1_cpu_en", {31'd0, cpu_en}, 32'd0);
        tick();
        check("go2_cpu_en", {31'd0, cpu_en}, 32'd0);
        check("go2_cycle", cycle_cnt, 32'd7);
        tick();
        check("go3_cpu_en", {31'd0, cpu_en}, 32'd1);
        check("go3_paused", {31'd0, paused}, 32'd0);
        for (int k = 4; k <= 20; k++) tick();
        check("hold_cycle", cycle_cnt, 32'd24);
        // Re-pause with go still held: no new pulse may resume
        do_syscall(32'd5, 32'd0);
        repeat (5) tick();
        check("held_no_resume", {31'd0, paused}, 32'd1);
        check("held_cycle", cycle_cnt, 32'd25);
        go = 1'b0;
        repeat (3) tick();
        check("release_paused", {31'd0, paused}, 32'd1);
        go = 1'b1;
        tick();
        go = 1'b0;
        tick();
        tick();
        check("short_press_run", {31'd0, cpu_en}, 32'd1);
        check("short_press_cycle", cycle_cnt, 32'd25);

        // Exit halts permanently
        do_syscall(32'd10, 32'd0);
        check("exit_halted", {31'd0, halted}, 32'd1);
        check("exit_cpu_en", {31'd0, cpu_en}, 32'd0);
        for (int p = 0; p < 3; p++) begin
            go = 1'b1;
            tick();
            go = 1'b0;
            repeat (3) tick();
        end
        check("halt_ignores_go", {31'd0, halted}, 32'd1);
        check("halt_cpu_en", {31'd0, cpu_en}, 32'd0);
        check("halt_cycle", cycle_cnt, 32'd26);
        rst = 1'b0;
        #1;
        check("halt_rst_halted", {31'd0, halted}, 32'd0);
        check("halt_rst_cpu_en", {31'd0, cpu_en}, 32'd1);
        check("halt_rst_cycle", cycle_cnt, 32'd0);
        check("halt_rst_disp", {16'd0, disp_cnt}, 32'd0);
        tick();
        rst = 1'b1;

        // Single step
        tick();
        check("pre_step_cycle", cycle_cnt, 32'd1);
        step_en = 1'b1;
        tick();
        check("step_cpu_en_idle", {31'd0, cpu_en}, 32'd0);
        check("step_entry_cycle", cycle_cnt, 32'd2);
        // Syscall while stalled is ignored
        do_syscall(32'd34, 32'h0BADF00D);
        check("stalled_sys_led", led_data, 32'd0);
        check("stalled_sys_disp", {16'd0, disp_cnt}, 32'd0);
        for (int s = 0; s < 4; s++) begin
            go = 1'b1;
            tick();
            check("step_pre_pulse", {31'd0, cpu_en}, 32'd0);
            go = 1'b0;
            tick();
            check("step_pulse", {31'd0, cpu_en}, 32'd1);
            if (s == 2) do_syscall(32'd34, 32'h12345678);
            else if (s == 3) do_syscall(32'd5, 32'd0);
            else tick();
            check("step_post_pulse", {31'd0, cpu_en}, 32'd0);
        end
        check("step_cycle", cycle_cnt, 32'd6);
        check("step_led", led_data, 32'h12345678);
        check("step_disp", {16'd0, disp_cnt}, 32'd1);
        check("step_pause", {31'd0, paused}, 32'd1);
        // Leaving PAUSE must not also execute an instruction
        go = 1'b1;
        tick();
        go = 1'b0;
        for (int t = 0; t < 3; t++) begin
            check("unpause_no_exec", {31'd0, cpu_en}, 32'd0);
            tick();
        end
        check("unpause_paused", {31'd0, paused}, 32'd0);
        check("unpause_cycle", cycle_cnt, 32'd6);

        // Async reset while paused with disp_cnt=3
        step_en = 1'b0;
        tick();
        check("back_to_run", {31'd0, cpu_en}, 32'd1);
        do_syscall(32'd34, 32'h00000011);
        do_syscall(32'd34, 32'h00000022);
        do_syscall(32'd7, 32'd0);
        check("p3_paused", {31'd0, paused}, 32'd1);
        check("p3_disp", {16'd0, disp_cnt}, 32'd3);
        check("p3_led", led_data, 32'h00000022);
        check("p3_cycle", cycle_cnt, 32'd9);
        rst = 1'b0;
        #1;
        check("arst_paused", {31'd0, paused}, 32'd0);
        check("arst_cpu_en", {31'd0, cpu_en}, 32'd1);
        check("arst_disp", {16'd0, disp_cnt}, 32'd0);
        check("arst_led", led_data, 32'd0);
        tick();
        rst = 1'b1;
        tick();

        $display("%0d/%0d checks passed", n_checks - n_fail, n_checks);
        $finish;
    end

endmodule

// File: doc/syscall_run_ctrl.md
Name: syscall_run_ctrl

Overview:
Run/halt sequencer for the single-cycle CPU core. Decodes the syscall service code in v0 each committed instruction and gates the core clock-enable. It latches display values to the LED bus, pauses on unknown services until the go button is pressed, stops permanently on exit, and supports single-step via go. It also provides execution and display counters for the board's seven-segment display.

Parameters:
DISP_CODE, 34, v0 value meaning "show a0 on LEDs and continue"
EXIT_CODE, 10, v0 value meaning "terminate program; halt until reset"
CNT_W, 32, width of executed-cycle counter

Ports:
clk  input  1  system clock
rst  input  1  asynchronous, active-low reset
go  input  1  raw go/resume push button, asynchronous to clk
step_en  input  1  single-step mode switch (level)
syscall  input  1  current instruction is SYSCALL (from decoder)
v0  input  32  register $v0 value (service code)
a0  input  32  register $a0 value (argument)
cpu_en  output  1  core enable: PC update and register/memory writes commit only when high
led_data  output  32  last displayed a0 value
halted  output  1  high in HALT state
paused  output  1  high in PAUSE state
cycle_cnt  output  CNT_W  number of cycles with cpu_en high
disp_cnt  output  16  number of display syscalls executed

Behaviour:
- Reset (rst low, async): state=RUN, led_data=0, cycle_cnt=0, disp_cnt=0, go synchronizer flops=0. Outputs after reset: cpu_en=1, halted=0, paused=0.
- go path: 2-flop synchronizer (s1, s2) followed by delay flop s3. go_pulse = s2 & ~s3. One pulse per press regardless of hold length. go_pulse is high in the cycle after the 2nd edge that samples go high.
- States: RUN, STEP, PAUSE, HALT. All are registered; outputs are decoded from state.
- cpu_en = (RUN) | (STEP & go_pulse). paused = (PAUSE). halted = (HALT).
- commit = cpu_en & syscall. A syscall is only acted on when committed; syscall with cpu_en=0 is ignored.
- Service decode on commit, priority top-down:
  - v0==EXIT_CODE: next state HALT.
  - v0==DISP_CODE: led_data<=a0 and disp_cnt<=disp_cnt+1 (wraps 0xFFFF->0) at the same edge. State stays RUN, or STEP if in STEP.
  - Any other v0: next state PAUSE.
- No committed syscall:
  - RUN: step_en=1 -> STEP, else stay.
  - STEP: step_en=0 -> RUN, else stay.
  - PAUSE: go_pulse -> RUN if step_en=0, STEP if step_en=1; else stay.
  - HALT: stay until reset; go_pulse is ignored.
- The syscall instruction itself commits (cpu_en high that cycle). The core stops from the following cycle. Latency from syscall commit to cpu_en=0 is 1 cycle.
- In STEP, a pausing syscall committed on a go_pulse cycle goes to PAUSE. The next go_pulse leaves PAUSE but does not also execute an instruction.
- cycle_cnt increments every cycle cpu_en=1 and saturates at all-ones. disp_cnt wraps.
- Reset mid-PAUSE/HALT/STEP: immediate return to RUN with counters cleared.
- v0/a0 are compared on their full 32 bits. No sign handling.

Test Plan:
- Reset then 5 idle cycles, syscall=0 -> cpu_en=1 throughout, cycle_cnt=5, led_data=0, paused=halted=0.
- syscall=1, v0=34, a0=0xDEADBEEF for one cycle -> next edge led_data=0xDEADBEEF, disp_cnt=1, cpu_en stays 1.
- syscall=1, v0=5 -> cpu_en=0 and paused=1 from the next cycle. Hold go high 20 cycles -> exactly one resume, cpu_en=1 returns 3 cycles after go rises, cycle_cnt does not count the paused cycles.
- syscall=1, v0=10 -> halted=1, cpu_en=0. Pulse go 3 times -> remains halted. Pull rst low -> immediately RUN with all counters 0.
- step_en=1 from RUN -> STEP. Press go 4 times -> cpu_en high exactly 4 single cycles, cycle_cnt increments by 4. A v0=34 syscall on one of those steps updates led_data and stays in STEP.
- Assert rst low while paused with disp_cnt=3 -> state RUN, disp_cnt=0, led_data=0, paused=0 asynchronously, before the next clk edge.
